// File: rtl/filtros_pkg.sv
// -----------------------------------------------------------------------------
// filtros_pkg
// Types and defaults shared by the filter datapath blocks (3-lane adder,
// lane distributor).
//   DATA_WIDTH : default sample width (two's complement)
//   LANES      : default number of parallel lanes
//   sample_t   : signed sample type
//   state_t    : output holding register state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package filtros_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int LANES      = 3;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    // EMPTY: no frame presented (out_valid = 0)
    // FULL : a frame is held on lane_data (out_valid = 1)
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Width of a counter holding 0..lanes (fill count of a frame).
    function automatic int fill_width(input int lanes);
        return $clog2(lanes + 1);
    endfunction

endpackage

// File: rtl/distribuidor_3_lanes_if.sv
// -----------------------------------------------------------------------------
// distribuidor_3_lanes_if
// Stream-in / frame-out bus of the lane distributor.
//   in_data/in_valid/in_ready      : serial sample stream
//   lane_data/out_valid/out_ready  : parallel frame, lane i at
//                                    [i*DATA_WIDTH +: DATA_WIDTH]
//   flush/out_fill                 : present only with DISTRIBUIDOR_FLUSH_EN
// Handshake rule (both sides): a transfer happens on a rising clock edge where
// valid && ready. A valid source keeps valid high and its data stable until
// the transfer; ready never depends combinationally on valid.
// Modports:
//   master : the environment (sample producer and frame consumer)
//   slave  : the distributor
// -----------------------------------------------------------------------------
interface distribuidor_3_lanes_if #(
    parameter int DATA_WIDTH = filtros_pkg::DATA_WIDTH,
    parameter int LANES      = filtros_pkg::LANES
);

    logic [DATA_WIDTH-1:0]       in_data;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANES*DATA_WIDTH-1:0] lane_data;
    logic                        out_valid;
    logic                        out_ready;

`ifdef DISTRIBUIDOR_FLUSH_EN
    logic                          flush;
    logic [$clog2(LANES+1)-1:0]    out_fill;

    modport master (
        output in_data, in_valid, out_ready, flush,
        input  in_ready, lane_data, out_valid, out_fill
    );

    modport slave (
        input  in_data, in_valid, out_ready, flush,
        output in_ready, lane_data, out_valid, out_fill
    );
`else
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, lane_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, lane_data, out_valid
    );
`endif

endinterface

// File: rtl/distribuidor_3_lanes_registro_salida_lanes.sv
// -----------------------------------------------------------------------------
// registro_salida_lanes
// Output holding register of the lane distributor. Holds one parallel frame
// and its valid flag; the frame stays stable until the consumer takes it.
// The loader only asserts i_load when the register is empty or being drained
// in the same cycle, so a load never overwrites an unaccepted frame.
// Ports:
//   clk, reset_n  : clock, synchronous active-low reset
//   i_load        : load i_frame (and i_fill) this cycle
//   i_frame       : frame to load
//   i_fill        : number of valid lanes (DISTRIBUIDOR_FLUSH_EN only)
//   i_out_ready   : consumer accepts the held frame
//   o_lane_data   : held frame
//   o_out_valid   : frame held
//   o_fill        : fill count of held frame (DISTRIBUIDOR_FLUSH_EN only)
//   o_state       : FSM state, for observation
// -----------------------------------------------------------------------------
module registro_salida_lanes #(
    parameter int DATA_WIDTH = filtros_pkg::DATA_WIDTH,
    parameter int LANES      = filtros_pkg::LANES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i_load,
    input  logic [LANES*DATA_WIDTH-1:0]   i_frame,
`ifdef DISTRIBUIDOR_FLUSH_EN
    input  logic [$clog2(LANES+1)-1:0]    i_fill,
    output logic [$clog2(LANES+1)-1:0]    o_fill,
`endif
    input  logic                          i_out_ready,
    output logic [LANES*DATA_WIDTH-1:0]   o_lane_data,
    output logic                          o_out_valid,
    output filtros_pkg::state_t           o_state
);

    filtros_pkg::state_t           r_state;
    filtros_pkg::state_t           w_next_state;
    logic [LANES*DATA_WIDTH-1:0]   r_lane_data;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= filtros_pkg::EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A load while FULL is only issued together with a drain, so the state
    // stays FULL and the new frame replaces the one just taken.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            filtros_pkg::EMPTY: begin
                if (i_load) begin
                    w_next_state = filtros_pkg::FULL;
                end
            end
            filtros_pkg::FULL: begin
                if (i_load) begin
                    w_next_state = filtros_pkg::FULL;
                end else if (i_out_ready) begin
                    w_next_state = filtros_pkg::EMPTY;
                end
            end
            default: begin
                w_next_state = filtros_pkg::EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_lane_data <= '0;
        end else if (i_load) begin
            r_lane_data <= i_frame;
        end
    end

`ifdef DISTRIBUIDOR_FLUSH_EN
    logic [$clog2(LANES+1)-1:0] r_fill;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fill <= '0;
        end else if (i_load) begin
            r_fill <= i_fill;
        end
    end

    assign o_fill = r_fill;
`endif

    assign o_lane_data = r_lane_data;
    assign o_out_valid = (r_state == filtros_pkg::FULL);
    assign o_state     = r_state;

endmodule

// File: rtl/distribuidor_3_lanes.sv
// -----------------------------------------------------------------------------
// distribuidor_3_lanes
// Serial-to-parallel lane distributor: collects signed samples round-robin
// into LANES slots and presents each complete group as one parallel frame.
// Optional feature macro: DISTRIBUIDOR_FLUSH_EN (adds flush / out_fill to
// close partial frames, unused lanes zeroed).
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : distribuidor_3_lanes_if.slave (stream in, frame out)
//   o_dbg_state  : output register FSM state, for observation
// -----------------------------------------------------------------------------
module distribuidor_3_lanes #(
    parameter int DATA_WIDTH = filtros_pkg::DATA_WIDTH,
    parameter int LANES      = filtros_pkg::LANES
) (
    input  logic                    clk,
    input  logic                    reset_n,
    distribuidor_3_lanes_if.slave   bus,
    output filtros_pkg::state_t     o_dbg_state
);

    localparam int                IDX_W    = $clog2(LANES);
    localparam int                FILL_W   = filtros_pkg::fill_width(LANES);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    logic [IDX_W-1:0]            r_idx;
    logic [DATA_WIDTH-1:0]       r_buf [LANES];

    logic                        w_out_valid;
    logic                        w_stall;
    logic                        w_in_ready;
    logic                        w_accept;
    logic                        w_last;
    logic                        w_close;
    logic [LANES*DATA_WIDTH-1:0] w_frame;

    // A held frame that is not being taken blocks anything that would load
    // the output register (the completing sample, or a flush).
    assign w_stall = w_out_valid && !bus.out_ready;

`ifdef DISTRIBUIDOR_FLUSH_EN
    logic              w_flush_go;
    logic [FILL_W-1:0] w_fill;

    assign w_in_ready = !w_stall || ((r_idx != LAST_IDX) && !bus.flush);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = w_accept && (r_idx == LAST_IDX);
    // Flush only closes a frame that holds at least one sample, counting the
    // one accepted in this cycle.
    assign w_flush_go = bus.flush && !w_stall && ((r_idx != '0) || w_accept);
    assign w_close    = w_last || w_flush_go;
    assign w_fill     = FILL_W'(r_idx) + FILL_W'(w_accept);
`else
    assign w_in_ready = !w_stall || (r_idx != LAST_IDX);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = w_accept && (r_idx == LAST_IDX);
    assign w_close    = w_last;
`endif

    // Frame seen by the output register: filled slots from the collect
    // buffer, the sample accepted this cycle in its slot, zeros above.
    always_comb begin
        w_frame = '0;
        for (int i = 0; i < LANES; i++) begin
            if (IDX_W'(i) < r_idx) begin
                w_frame[i*DATA_WIDTH +: DATA_WIDTH] = r_buf[i];
            end else if ((IDX_W'(i) == r_idx) && w_accept) begin
                w_frame[i*DATA_WIDTH +: DATA_WIDTH] = bus.in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_idx <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_buf[r_idx] <= bus.in_data;
            end
            if (w_close) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    registro_salida_lanes #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES)
    ) u_registro_salida_lanes (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_close),
        .i_frame     (w_frame),
`ifdef DISTRIBUIDOR_FLUSH_EN
        .i_fill      (w_fill),
        .o_fill      (bus.out_fill),
`endif
        .i_out_ready (bus.out_ready),
        .o_lane_data (bus.lane_data),
        .o_out_valid (w_out_valid),
        .o_state     (o_dbg_state)
    );

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;

endmodule

// File: doc/distribuidor_3_lanes.md
# distribuidor_3_lanes

Serial-to-parallel lane distributor for the filter datapath, the inverse of the 3-lane adder. It accepts a stream of signed 11-bit samples over a valid/ready handshake and distributes them in round-robin order into lanes 0..LANES-1. Each complete group is presented as one parallel frame with its own valid/ready handshake. It feeds the parallel lanes of the filter structure ahead of the per-lane multiply/sum stages.

## Interface
- DATA_WIDTH, 11: sample width, two's complement.
- LANES, 3: lanes per frame, 2..8.
- clk  in  1  single clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_data  in  DATA_WIDTH  input sample, signed.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample this cycle.
- lane_data  out  LANES*DATA_WIDTH  frame; lane i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  lane_data holds a frame.
- out_ready  in  1  downstream accepts the frame.
- flush  in  1  close a partial frame (only with DISTRIBUIDOR_FLUSH_EN).
- out_fill  out  $clog2(LANES+1)  number of valid lanes in the frame (only with DISTRIBUIDOR_FLUSH_EN).

## Operation
- Handshakes: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Collect buffer: LANES registers plus a slot counter `idx` (0..LANES-1). An accepted sample is written to slot idx, and idx increments. After slot LANES-1, idx wraps to 0 and the collect buffer is copied to the output register.
- Output register holds lane_data and out_valid. Once out_valid rises, it stays high and lane_data stays stable until the frame is accepted.
- States:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
  - EMPTY -> FULL when the last slot is accepted.
  - FULL -> EMPTY on output transfer with no simultaneous frame completion.
  - FULL -> FULL on output transfer plus a simultaneous completion; the new frame loads in the same cycle.
- in_ready = (idx != LANES-1) || !out_valid || out_ready. Collection of the next frame continues while a frame is held. Only the completing sample is stalled.
- Data passes through bit-exact; there is no arithmetic or sign change.
- Reset (reset_n = 0 at a clock edge) has priority over everything:
  - idx = 0, out_valid = 0, lane_data = 0, collect buffer = 0, out_fill = 0.
  - A partial frame or held frame in flight is discarded.
  - in_ready is 1 in the first cycle after reset.

## Timing
- Latency: the frame appears with out_valid = 1 one cycle after the edge that accepts the LANES-th sample.
- Sustained throughput is 1 sample/cycle with out_ready held at 1: one frame every LANES cycles, no bubbles.
- in_ready is combinational from idx, out_valid and out_ready. There is no combinational path from in_valid to in_ready or to out_valid.
- When out_ready is low with a frame held and idx = LANES-1, in_ready = 0 until the cycle out_ready = 1.

## Configuration
- Macro: DISTRIBUIDOR_FLUSH_EN.
- When defined, flush and out_fill exist.
  - flush with idx > 0 (counting a sample accepted in the same cycle) closes the frame. It loads the filled slots, zeroes the remaining lanes, sets out_fill = number of filled slots, and sets idx = 0.
  - flush when idx = 0 and no sample is accepted is ignored.
  - flush is subject to the same stall rule as a completing sample: while a frame is held and out_ready = 0, the flush is held off and in_ready = 0.
  - A full frame sets out_fill = LANES.
- When undefined, neither port exists and behaviour is only full frames.

## Structure
- Shared package `filtros_pkg` holds:
  - DATA_WIDTH default (11), shared with the adder.
  - LANES default (3).
  - typedef sample_t (signed [DATA_WIDTH-1:0]).
  - the state encoding (EMPTY = 1'b0, FULL = 1'b1).
- One natural sub-module: `registro_salida_lanes`, the output holding register with its valid/ready logic.

## Test plan
- Reset, then in 5,5,2 with out_ready = 1 -> one cycle after the 3rd accept: lane0 = 5, lane1 = 5, lane2 = 2, out_valid = 1 for exactly one cycle.
- Stream 4,-10,-1,3,7,-1024 back-to-back with out_ready = 1 -> in_ready stays 1 throughout. Frames are {4,-10,-1} (-10 = 11'h7F6) and {3,7,-1024} (-1024 = 11'h400), three cycles apart.
- Hold out_ready = 0 after frame {1,2,3}, then send 4,5,6 -> 4 and 5 accepted, in_ready = 0 with 6 pending, lane_data stable at {1,2,3}. Raising out_ready lets 6 be accepted that cycle, and {4,5,6} is presented the next cycle.
- Assert reset_n = 0 after 2 samples of a frame -> out_valid = 0. The next 3 samples 7,8,9 form frame {7,8,9}.
- With DISTRIBUIDOR_FLUSH_EN: send 5, then flush -> frame {5,0,0}, out_fill = 1. Flush with idx = 0 -> no frame.
